// File: rtl/fpu_shared_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_shared_arbiter
// Purpose  : Shares one FPU datapath between NUM_REQ requesters. Round-robin
//            arbitration and one issue per cycle. Pipelined ops, NOPs and
//            invalid ops return LATENCY cycles after their grant. The returned
//            result is routed back to its owner through a shift register of
//            {valid, id, kind}. Iterative div/sqrt ops are serialized by a
//            small FSM (IDLE / DRAIN / DIVSQRT).
// Config   : `FPU_ARB_DIVSQRT_EN enables the div/sqrt path. When the macro is
//            undefined, DIV and SQRT are treated as invalid commands and
//            FpuDivSqrtDone_SI is ignored.
// Ports    : Clk_CI, Rst_RBI (async, active low)
//            Req_SI/Op_DI/RM_DI/OpA_DI/OpB_DI/OpC_DI   - core request side
//            Gnt_SO                                    - one-hot grant
//            FpuValid_SO/FpuOp_DO/FpuRM_DO/FpuOp*_DO   - issue to shared FPU
//            FpuResult_DI/FpuFlags_DI/FpuDivSqrtDone_SI - FPU return side
//            RValid_SO/Result_DO/Flags_DO              - result back to cores
// Revision : 1.0 - initial release
// ============================================================================
module fpu_shared_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 2,
    localparam int C_CMD   = 4,
    localparam int C_RM    = 3,
    localparam int C_OP    = 32,
    localparam int C_FFLAG = 5
) (
    input  logic                       Clk_CI,
    input  logic                       Rst_RBI,
    input  logic [NUM_REQ-1:0]         Req_SI,
    input  logic [NUM_REQ*C_CMD-1:0]   Op_DI,
    input  logic [NUM_REQ*C_RM-1:0]    RM_DI,
    input  logic [NUM_REQ*C_OP-1:0]    OpA_DI,
    input  logic [NUM_REQ*C_OP-1:0]    OpB_DI,
    input  logic [NUM_REQ*C_OP-1:0]    OpC_DI,
    output logic [NUM_REQ-1:0]         Gnt_SO,
    output logic                       FpuValid_SO,
    output logic [C_CMD-1:0]           FpuOp_DO,
    output logic [C_RM-1:0]            FpuRM_DO,
    output logic [C_OP-1:0]            FpuOpA_DO,
    output logic [C_OP-1:0]            FpuOpB_DO,
    output logic [C_OP-1:0]            FpuOpC_DO,
    input  logic [C_OP-1:0]            FpuResult_DI,
    input  logic [C_FFLAG-1:0]         FpuFlags_DI,
    input  logic                       FpuDivSqrtDone_SI,
    output logic [NUM_REQ-1:0]         RValid_SO,
    output logic [C_OP-1:0]            Result_DO,
    output logic [C_FFLAG-1:0]         Flags_DO
);

    localparam int C_IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Command encodings of fpu_defs used for classification
    localparam logic [C_CMD-1:0] C_CMD_DIV  = 4'h3;
    localparam logic [C_CMD-1:0] C_CMD_SQRT = 4'h6;
    localparam logic [C_CMD-1:0] C_CMD_NOP  = 4'h7;

    // Canonical quiet NaN with the invalid-operation flag (NV is bit 4)
    localparam logic [C_OP-1:0]    C_QNAN   = 32'h7FC0_0000;
    localparam logic [C_FFLAG-1:0] C_NV     = 5'b10000;

    // Command classes; the first three double as the tracked result kind
    localparam logic [1:0] C_CL_FPU = 2'd0;
    localparam logic [1:0] C_CL_NOP = 2'd1;
    localparam logic [1:0] C_CL_INV = 2'd2;
`ifdef FPU_ARB_DIVSQRT_EN
    localparam logic [1:0] C_CL_DS  = 2'd3;

    localparam logic [1:0] C_ST_IDLE    = 2'd0;
    localparam logic [1:0] C_ST_DRAIN   = 2'd1;
    localparam logic [1:0] C_ST_DIVSQRT = 2'd2;
`endif

    function automatic logic [1:0] classify(input logic [C_CMD-1:0] op,
                                            input logic [C_RM-1:0]  rm);
        logic [1:0] cls;
        cls = C_CL_FPU;
        if (op >= 4'hC || rm >= 3'd5) begin
            cls = C_CL_INV;
        end else if (op == C_CMD_NOP) begin
            cls = C_CL_NOP;
        end else if (op == C_CMD_DIV || op == C_CMD_SQRT) begin
`ifdef FPU_ARB_DIVSQRT_EN
            cls = C_CL_DS;
`else
            cls = C_CL_INV;
`endif
        end
        return cls;
    endfunction

    logic [C_IW-1:0]    r_ptr;
    logic [LATENCY-1:0] r_pv;
    logic [C_IW-1:0]    r_pid   [LATENCY];
    logic [1:0]         r_pkind [LATENCY];

    logic               w_win_found;
    logic [C_IW-1:0]    w_win_idx;
    logic [1:0]         w_win_cls;
    logic               w_pipe_empty;
    logic               w_gnt_raw;
    logic               w_gnt_ok;
    logic [C_IW-1:0]    w_gnt_idx;
    logic               w_issue_ds;
    logic               w_push;

    // ------------------------------------------------------------------
    // Round-robin winner search starting at r_ptr
    // ------------------------------------------------------------------
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_win_found && Req_SI[C_IW'((int'(r_ptr) + k) % NUM_REQ)]) begin
                w_win_found = 1'b1;
                w_win_idx   = C_IW'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_win_cls    = classify(Op_DI[w_win_idx*C_CMD +: C_CMD],
                                   RM_DI[w_win_idx*C_RM +: C_RM]);
    assign w_pipe_empty = ~|r_pv;

`ifdef FPU_ARB_DIVSQRT_EN
    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [C_IW-1:0] r_dsid;
    logic            w_dsid_load;

    always_comb begin
        w_gnt_raw    = 1'b0;
        w_gnt_idx    = w_win_idx;
        w_issue_ds   = 1'b0;
        w_dsid_load  = 1'b0;
        w_next_state = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (w_win_found) begin
                    if (w_win_cls == C_CL_DS) begin
                        // A div/sqrt may only start once nothing pipelined
                        // can still claim the result port.
                        w_dsid_load = 1'b1;
                        if (w_pipe_empty) begin
                            w_gnt_raw    = 1'b1;
                            w_issue_ds   = 1'b1;
                            w_next_state = C_ST_DIVSQRT;
                        end else begin
                            w_next_state = C_ST_DRAIN;
                        end
                    end else begin
                        w_gnt_raw = 1'b1;
                    end
                end
            end
            C_ST_DRAIN: begin
                // Issue to the latched owner even if it dropped its request
                if (w_pipe_empty) begin
                    w_gnt_raw    = 1'b1;
                    w_gnt_idx    = r_dsid;
                    w_issue_ds   = 1'b1;
                    w_next_state = C_ST_DIVSQRT;
                end
            end
            C_ST_DIVSQRT: begin
                if (FpuDivSqrtDone_SI) begin
                    w_next_state = C_ST_IDLE;
                end
            end
            default: begin
                w_next_state = C_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_state <= C_ST_IDLE;
            r_dsid  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_dsid_load) begin
                r_dsid <= w_win_idx;
            end
        end
    end
`else
    always_comb begin
        w_gnt_raw  = w_win_found;
        w_gnt_idx  = w_win_idx;
        w_issue_ds = 1'b0;
    end

    logic w_unused_done;
    assign w_unused_done = FpuDivSqrtDone_SI;
`endif

    // Reset forces every combinational issue output low even with requests up
    assign w_gnt_ok = w_gnt_raw & Rst_RBI;
    assign w_push   = w_gnt_ok & ~w_issue_ds;

    // ------------------------------------------------------------------
    // Pointer and result-tracking shift register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_ptr <= '0;
            r_pv  <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_pid[i]   <= '0;
                r_pkind[i] <= C_CL_FPU;
            end
        end else begin
            if (w_gnt_ok) begin
                r_ptr <= (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + C_IW'(1);
            end
            r_pv[0]    <= w_push;
            r_pid[0]   <= w_gnt_idx;
            r_pkind[0] <= w_win_cls;
            for (int i = 1; i < LATENCY; i++) begin
                r_pv[i]    <= r_pv[i-1];
                r_pid[i]   <= r_pid[i-1];
                r_pkind[i] <= r_pkind[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue side: grant and FPU pass-through
    // ------------------------------------------------------------------
    always_comb begin
        Gnt_SO      = '0;
        FpuValid_SO = 1'b0;
        FpuOp_DO    = '0;
        FpuRM_DO    = '0;
        FpuOpA_DO   = '0;
        FpuOpB_DO   = '0;
        FpuOpC_DO   = '0;
        if (w_gnt_ok) begin
            Gnt_SO[w_gnt_idx] = 1'b1;
            // NOP and invalid ops are answered locally, never sent to the FPU
            FpuValid_SO = w_issue_ds || (w_win_cls == C_CL_FPU);
            FpuOp_DO    = Op_DI[w_gnt_idx*C_CMD +: C_CMD];
            FpuRM_DO    = RM_DI[w_gnt_idx*C_RM +: C_RM];
            FpuOpA_DO   = OpA_DI[w_gnt_idx*C_OP +: C_OP];
            FpuOpB_DO   = OpB_DI[w_gnt_idx*C_OP +: C_OP];
            FpuOpC_DO   = OpC_DI[w_gnt_idx*C_OP +: C_OP];
        end
    end

    // ------------------------------------------------------------------
    // Return side: pipeline output stage or div/sqrt completion
    // ------------------------------------------------------------------
    always_comb begin
        RValid_SO = '0;
        Result_DO = '0;
        Flags_DO  = '0;
        if (r_pv[LATENCY-1]) begin
            RValid_SO[r_pid[LATENCY-1]] = 1'b1;
            case (r_pkind[LATENCY-1])
                C_CL_FPU: begin
                    Result_DO = FpuResult_DI;
                    Flags_DO  = FpuFlags_DI;
                end
                C_CL_NOP: begin
                    Result_DO = '0;
                    Flags_DO  = '0;
                end
                default: begin
                    Result_DO = C_QNAN;
                    Flags_DO  = C_NV;
                end
            endcase
        end
`ifdef FPU_ARB_DIVSQRT_EN
        // The pipeline is empty throughout DIVSQRT, so no port conflict here
        if (r_state == C_ST_DIVSQRT && FpuDivSqrtDone_SI) begin
            RValid_SO[r_dsid] = 1'b1;
            Result_DO         = FpuResult_DI;
            Flags_DO          = FpuFlags_DI;
        end
`endif
    end

endmodule
`default_nettype wire
